row_pixel_scanner: RTL and testbench
====================================

Name: row_pixel_scanner

Overview:
- Sequential front end for the 64:1 single-bit pixel mux in the segmentation path.
- Accepts one 64-bit binarized image row and holds it on the mux data bus.
- Steps the mux select 0..63, consumes the selected bit each cycle, and produces per-row features for the bounding-box / segmentation logic downstream: black-pixel count, first and last set column.

Parameters:
- IWIDTH, 64, row width in pixels; fixed at 64 to match the 6-bit mux select.
- SWIDTH, 6, select width, log2(IWIDTH).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  row_in is valid.
- in_ready  output  1  block can accept a row.
- row_in  input  64  binarized row; bit i = column i, 1 = ink.
- mux_in  output  64  registered row, drives the mux data input.
- mux_sel  output  6  registered column select to the mux.
- mux_bit  input  1  mux output, combinational function of mux_in/mux_sel.
- out_valid  output  1  feature result valid.
- out_ready  input  1  consumer accepts result.
- pix_count  output  7  number of set pixels, 0..64.
- first_idx  output  6  lowest set column.
- last_idx  output  6  highest set column.
- row_empty  output  1  no set pixel in row.
- run_count  output  6  number of ink runs (optional feature).

Behaviour:
- Reset (rst=1 at clk edge; takes priority over all other inputs, including mid-scan):
  - State returns to IDLE.
  - in_ready=1, out_valid=0.
  - mux_in=0, mux_sel=0.
  - pix_count=0, first_idx=0, last_idx=0, row_empty=1, run_count=0.
  - Any partial scan is discarded.
- State machine IDLE -> SCAN -> DONE -> IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready at edge T: mux_in<=row_in, mux_sel<=0, accumulators cleared, go to SCAN.
- SCAN:
  - in_ready=0; occupies 64 cycles, edges T+1..T+64.
  - Each cycle mux_bit is sampled for column = mux_sel.
  - If mux_bit=1: count += 1; if no pixel seen yet, first<=mux_sel; last<=mux_sel.
  - mux_sel increments by 1 per cycle. At mux_sel=63 the final bit is folded in, and the state moves to DONE; mux_sel wraps to 0.
- DONE:
  - out_valid=1 from edge T+64, so a result is visible 64 cycles after input acceptance.
  - Outputs stay stable until out_valid&out_ready, then go to IDLE.
  - in_ready=0 throughout DONE; a row presented during DONE is not taken until IDLE.
  - Row period with out_ready tied high: 66 cycles.
- Arithmetic and width rules:
  - pix_count is 7 bits so 64 does not overflow.
  - Empty row: pix_count=0, first_idx=0, last_idx=0, row_empty=1.
  - Otherwise row_empty=0 and first_idx<=last_idx.
- Result registers keep their last values while in IDLE/SCAN. Only out_valid qualifies them.
- mux_in holds the accepted row until the next acceptance.

Optional Feature:
- Macro: ROW_PIXEL_SCANNER_RUNLEN_EN.
- Defined:
  - Track the previous scanned bit (initialized to 0 at scan start).
  - run_count increments on every 0->1 transition, so range is 0..32.
  - Valid with the other outputs in DONE.
- Undefined:
  - No previous-bit or run logic is built; run_count is tied to 0.
  - All other behaviour is identical.

Test Plan:
- row_in=64'h0000_0000_0000_0000 -> out_valid 64 cycles after accept; pix_count=0, first_idx=0, last_idx=0, row_empty=1, run_count=0.
- row_in=64'hFFFF_FFFF_FFFF_FFFF -> pix_count=64, first_idx=0, last_idx=63, row_empty=0, run_count=1 (feature on).
- row_in=64'h5555_5555_5555_5555 -> pix_count=32, first_idx=0, last_idx=62, run_count=32; check mux_sel steps 0..63 on consecutive cycles.
- row_in=64'h8000_0000_0000_0100 -> pix_count=2, first_idx=8, last_idx=63, run_count=2.
- Backpressure case:
  - Stimulus: out_ready=0 for 10 cycles in DONE, with in_valid=1 and a new row throughout.
  - Required: outputs stable, in_ready=0, new row not accepted. After out_ready=1, IDLE for one cycle, then the new row is accepted.
- Reset mid-scan case:
  - Stimulus: assert rst for 1 cycle when mux_sel=30.
  - Required: next cycle shows IDLE, in_ready=1, out_valid=0, mux_sel=0, row_empty=1. A subsequent row scans from column 0 with no residue from the aborted row.

Source files
------------

// File: rtl/row_pixel_scanner_if.sv
// Handshake, mux and feature-result bundle for row_pixel_scanner.
// The slave modport is the scanner; the master modport is the row source, mux and consumer.
interface row_pixel_scanner_if #(
  parameter int IWIDTH = 64,
  parameter int SWIDTH = 6
);
  logic              in_valid;
  logic              in_ready;
  logic [IWIDTH-1:0] row_in;
  logic [IWIDTH-1:0] mux_in;
  logic [SWIDTH-1:0] mux_sel;
  logic              mux_bit;
  logic              out_valid;
  logic              out_ready;
  logic [SWIDTH:0]   pix_count;
  logic [SWIDTH-1:0] first_idx;
  logic [SWIDTH-1:0] last_idx;
  logic              row_empty;
  logic [SWIDTH-1:0] run_count;

  modport slave (
    input  in_valid, row_in, mux_bit, out_ready,
    output in_ready, mux_in, mux_sel, out_valid,
    output pix_count, first_idx, last_idx, row_empty, run_count
  );

  modport master (
    output in_valid, row_in, mux_bit, out_ready,
    input  in_ready, mux_in, mux_sel, out_valid,
    input  pix_count, first_idx, last_idx, row_empty, run_count
  );
endinterface

// File: rtl/row_pixel_scanner.sv
// Steps a 64:1 pixel mux across a held row and reports count / first / last set column.
// Define ROW_PIXEL_SCANNER_RUNLEN_EN to also count ink runs; otherwise run_count is tied to 0.
module row_pixel_scanner #(
  parameter int IWIDTH = 64,
  parameter int SWIDTH = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  row_pixel_scanner_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_n;

  logic [IWIDTH-1:0] mux_in_q;
  logic [SWIDTH-1:0] sel_q;
  logic              last_col;
  logic              accept;

  logic [SWIDTH:0]   acc_cnt, cnt_n;
  logic [SWIDTH-1:0] acc_first, first_n;
  logic [SWIDTH-1:0] acc_last, last_n;

  logic [SWIDTH:0]   pix_q;
  logic [SWIDTH-1:0] first_q;
  logic [SWIDTH-1:0] last_q;
  logic              empty_q;

  assign last_col = (sel_q == '1);
  assign accept   = (state == IDLE) && bus.in_valid;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (bus.in_valid) state_n = SCAN;
      SCAN:    if (last_col) state_n = DONE;
      DONE:    if (bus.out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Accumulator update for the column currently on the mux; "no pixel yet" is acc_cnt == 0.
  always_comb begin
    cnt_n   = acc_cnt + {{SWIDTH{1'b0}}, bus.mux_bit};
    first_n = acc_first;
    last_n  = acc_last;
    if (bus.mux_bit) begin
      if (acc_cnt == '0) first_n = sel_q;
      last_n = sel_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mux_in_q  <= '0;
      sel_q     <= '0;
      acc_cnt   <= '0;
      acc_first <= '0;
      acc_last  <= '0;
      pix_q     <= '0;
      first_q   <= '0;
      last_q    <= '0;
      empty_q   <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            mux_in_q  <= bus.row_in;
            sel_q     <= '0;
            acc_cnt   <= '0;
            acc_first <= '0;
            acc_last  <= '0;
          end
        end
        SCAN: begin
          sel_q     <= sel_q + SWIDTH'(1);
          acc_cnt   <= cnt_n;
          acc_first <= first_n;
          acc_last  <= last_n;
          // Results are only published on the final column so they hold steady otherwise.
          if (last_col) begin
            pix_q   <= cnt_n;
            first_q <= first_n;
            last_q  <= last_n;
            empty_q <= (cnt_n == '0);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef ROW_PIXEL_SCANNER_RUNLEN_EN
  logic              prev_bit;
  logic [SWIDTH-1:0] acc_runs, runs_n, runs_q;

  assign runs_n = acc_runs + ((bus.mux_bit && !prev_bit) ? SWIDTH'(1) : SWIDTH'(0));

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_bit <= 1'b0;
      acc_runs <= '0;
      runs_q   <= '0;
    end else if (accept) begin
      prev_bit <= 1'b0;
      acc_runs <= '0;
    end else if (state == SCAN) begin
      prev_bit <= bus.mux_bit;
      acc_runs <= runs_n;
      if (last_col) runs_q <= runs_n;
    end
  end

  assign bus.run_count = runs_q;
`else
  assign bus.run_count = '0;
`endif

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.mux_in    = mux_in_q;
  assign bus.mux_sel   = sel_q;
  assign bus.pix_count = pix_q;
  assign bus.first_idx = first_q;
  assign bus.last_idx  = last_q;
  assign bus.row_empty = empty_q;

endmodule

// File: tb/tb_row_pixel_scanner.sv
// Directed bench for row_pixel_scanner: a bit-loop reference model feeds a result scoreboard,
// and the 64:1 mux is modelled combinationally from mux_in/mux_sel.
module tb_row_pixel_scanner;

  logic clk = 1'b0;
  logic rst = 1'b1;

  row_pixel_scanner_if #(.IWIDTH(64), .SWIDTH(6)) bus ();

  row_pixel_scanner #(.IWIDTH(64), .SWIDTH(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.mux_bit = bus.mux_in[bus.mux_sel];

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] row;
    logic [6:0]  cnt;
    logic [5:0]  first;
    logic [5:0]  last;
    logic        empty;
    logic [5:0]  runs;
  } exp_t;

  exp_t sb[$];
  int passed = 0;
  int total  = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [63:0] r);
    exp_t e;
    logic prev, seen;
    e.row = r; e.cnt = '0; e.first = '0; e.last = '0; e.runs = '0;
    prev = 1'b0; seen = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (r[i]) begin
        if (!seen) e.first = 6'(i);
        seen   = 1'b1;
        e.last = 6'(i);
        e.cnt  = e.cnt + 7'd1;
        if (!prev) e.runs = e.runs + 6'd1;
      end
      prev = r[i];
    end
    e.empty = !seen;
`ifndef ROW_PIXEL_SCANNER_RUNLEN_EN
    e.runs = '0;
`endif
    return e;
  endfunction

  // Presents a row, waits (bounded) for in_ready, and returns just after the accepting edge.
  task automatic accept_row(input logic [63:0] r);
    int w;
    w = 0;
    bus.in_valid = 1'b1;
    bus.row_in   = r;
    while (!bus.in_ready && w < 200) begin
      step();
      w++;
    end
    chk("in_ready_wait", 64'(bus.in_ready), 64'd1);
    step();
    bus.in_valid = 1'b0;
    sb.push_back(model(r));
    chk("mux_in_after_accept", bus.mux_in, r);
  endtask

  task automatic wait_result(input bit check_sel);
    int cyc;
    exp_t e;
    cyc = 0;
    while (!bus.out_valid && cyc < 200) begin
      if (check_sel) chk("mux_sel_step", 64'(bus.mux_sel), 64'(cyc[5:0]));
      step();
      cyc++;
    end
    chk("latency", 64'(cyc), 64'd64);
    chk("out_valid", 64'(bus.out_valid), 64'd1);
    if (bus.out_valid) begin
      chk("in_ready_done", 64'(bus.in_ready), 64'd0);
      chk("mux_sel_wrap", 64'(bus.mux_sel), 64'd0);
      chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("pix_count", 64'(bus.pix_count), 64'(e.cnt));
        chk("first_idx", 64'(bus.first_idx), 64'(e.first));
        chk("last_idx",  64'(bus.last_idx),  64'(e.last));
        chk("row_empty", 64'(bus.row_empty), 64'(e.empty));
        chk("run_count", 64'(bus.run_count), 64'(e.runs));
        chk("mux_in_hold", bus.mux_in, e.row);
      end
    end
  endtask

  initial begin
    logic [63:0] row_a, row_b;
    logic [6:0]  held_cnt;
    int w;

    bus.in_valid  = 1'b0;
    bus.row_in    = '0;
    bus.out_ready = 1'b1;

    // Reset state
    step(); step();
    rst = 1'b0;
    chk("rst_in_ready",  64'(bus.in_ready),  64'd1);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_mux_in",    bus.mux_in,         64'd0);
    chk("rst_mux_sel",   64'(bus.mux_sel),   64'd0);
    chk("rst_pix_count", 64'(bus.pix_count), 64'd0);
    chk("rst_first_idx", 64'(bus.first_idx), 64'd0);
    chk("rst_last_idx",  64'(bus.last_idx),  64'd0);
    chk("rst_row_empty", 64'(bus.row_empty), 64'd1);
    chk("rst_run_count", 64'(bus.run_count), 64'd0);

    // Directed rows; results consumed with out_ready high
    accept_row(64'h0000_0000_0000_0000); wait_result(1'b0); step();
    accept_row(64'hFFFF_FFFF_FFFF_FFFF); wait_result(1'b0); step();
    accept_row(64'h5555_5555_5555_5555); wait_result(1'b1); step();
    accept_row(64'h8000_0000_0000_0100); wait_result(1'b0); step();
    chk("idle_after_handshake", 64'(bus.in_ready), 64'd1);

    // Backpressure: result held while a new row is offered
    row_a = 64'h00F0_0000_0F00_3000;
    row_b = 64'h0000_0001_0000_0000;
    bus.out_ready = 1'b0;
    accept_row(row_a);
    wait_result(1'b0);
    held_cnt     = bus.pix_count;
    bus.in_valid = 1'b1;
    bus.row_in   = row_b;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
      chk("bp_in_ready",  64'(bus.in_ready),  64'd0);
      chk("bp_pix_stable", 64'(bus.pix_count), 64'(held_cnt));
      chk("bp_mux_in",    bus.mux_in,         row_a);
    end
    bus.out_ready = 1'b1;
    step();
    chk("bp_idle_in_ready",  64'(bus.in_ready),  64'd1);
    chk("bp_idle_out_valid", 64'(bus.out_valid), 64'd0);
    chk("bp_idle_mux_in",    bus.mux_in,         row_a);
    step();
    bus.in_valid = 1'b0;
    sb.push_back(model(row_b));
    chk("bp_new_row_taken", bus.mux_in, row_b);
    chk("bp_scan_in_ready", 64'(bus.in_ready), 64'd0);
    wait_result(1'b1); step();

    // Reset in the middle of a scan
    accept_row(64'hFFFF_FFFF_FFFF_FFFF);
    w = 0;
    while (bus.mux_sel != 6'd30 && w < 200) begin
      step();
      w++;
    end
    chk("reached_sel30", 64'(bus.mux_sel), 64'd30);
    rst = 1'b1;
    step();
    rst = 1'b0;
    void'(sb.pop_back());
    chk("mid_rst_in_ready",  64'(bus.in_ready),  64'd1);
    chk("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("mid_rst_mux_sel",   64'(bus.mux_sel),   64'd0);
    chk("mid_rst_row_empty", 64'(bus.row_empty), 64'd1);
    chk("mid_rst_pix_count", 64'(bus.pix_count), 64'd0);
    accept_row(64'h8000_0000_0000_0100); wait_result(1'b1); step();

    // A few pseudo-random rows
    for (int i = 0; i < 3; i++) begin
      accept_row({$urandom(), $urandom()});
      wait_result(1'b0);
      step();
    end
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
